// File: rtl/cash_port_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of a single-port cache/RAM; one request in flight.
// Latency: accept at A, memory issue at A+1, mem_q sampled at A+1+MEM_LAT, registered response at A+2+MEM_LAT.
// Backpressure: ready only in IDLE for the granted client; CASH_ARB_FIXED_PRIO_EN makes client 0 always win ties.
module cash_port_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] LAT3 = 3'(MEM_LAT);

    state_t            state;
    logic [2:0]        cnt;
    logic              lat_wr;
    logic              lat_owner;
    logic              grant;
    logic              accept;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] rsp_value;

`ifdef CASH_ARB_FIXED_PRIO_EN
    assign grant = ~req0_valid;
`else
    logic rr;

    // rr only matters on a tie; otherwise the lone valid client wins
    assign grant = (req0_valid && req1_valid) ? rr : req1_valid;
`endif

    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    assign sel_wr   = grant ? req1_wr   : req0_wr;
    assign sel_addr = grant ? req1_addr : req0_addr;
    assign sel_data = grant ? req1_data : req0_data;

    // mem_data still holds the latched write data, so it doubles as the echo source
    assign rsp_value = lat_wr ? mem_data : mem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
`ifndef CASH_ARB_FIXED_PRIO_EN
            rr         <= 1'b0;
`endif
            cnt        <= 3'd0;
            lat_wr     <= 1'b0;
            lat_owner  <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_wr     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            mem_wr     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_wr    <= sel_wr;
                        lat_owner <= grant;
                        mem_addr  <= sel_addr;
                        mem_data  <= sel_data;
                        mem_wr    <= sel_wr;
`ifndef CASH_ARB_FIXED_PRIO_EN
                        rr        <= ~grant;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= LAT3;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (lat_owner) begin
                            rsp1_data  <= rsp_value;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_data  <= rsp_value;
                            rsp0_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cash_port_arbiter.sv
// Bench for cash_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Instance dut uses MEM_LAT=1 with a RAM model; instance dut3 uses MEM_LAT=3 with mem_q = cycle number.
module tb_cash_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req0_valid, req0_ready, req0_wr, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data, rsp0_data;
    logic          req1_valid, req1_ready, req1_wr, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data, rsp1_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_q;
    logic          mem_wr;

    logic          b_req0_valid, b_req0_ready, b_req0_wr, b_rsp0_valid;
    logic [AW-1:0] b_req0_addr;
    logic [DW-1:0] b_req0_data, b_rsp0_data;
    logic          b_req1_valid, b_req1_ready, b_req1_wr, b_rsp1_valid;
    logic [AW-1:0] b_req1_addr;
    logic [DW-1:0] b_req1_data, b_rsp1_data;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_data, b_mem_q;
    logic          b_mem_wr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit [DW-1:0] mem [32];
    bit          pl_en = 1'b0;
    bit [4:0]    pl_addr = 5'd0;
    bit [DW-1:0] pl_data = '0;

    cash_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_q(mem_q)
    );

    cash_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_wr(b_req0_wr),
        .req0_addr(b_req0_addr), .req0_data(b_req0_data),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_wr(b_req1_wr),
        .req1_addr(b_req1_addr), .req1_data(b_req1_data),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_wr(b_mem_wr), .mem_q(b_mem_q)
    );

    // Single-port RAM with one cycle of read latency, plus a back door for preloading
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    assign b_mem_q = DW'(cyc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_data = '0;
        b_req0_valid = 0; b_req0_wr = 0; b_req0_addr = '0; b_req0_data = '0;
        b_req1_valid = 0; b_req1_wr = 0; b_req1_addr = '0; b_req1_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [DW-1:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        step();
        pl_en = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0_valid = 1; req0_addr = 5'd3;
        req1_valid = 1; req1_addr = 5'd4;
        for (int i = 0; i < 3; i++) begin
            step();
            samp();
            vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: ready0=%b ready1=%b want 0 0", req0_ready, req1_ready); end
            vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
            vectors++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b %b want 0 0", rsp0_valid, rsp1_valid); end
        end
        vectors++; if (mem_addr !== '0 || mem_data !== '0) begin miscompares++; $display("FAIL reset_mem_bus: addr=%h data=%h want 0 0", mem_addr, mem_data); end
        vectors++; if (rsp0_data !== '0 || rsp1_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h %h want 0 0", rsp0_data, rsp1_data); end
        step();
        rst_n = 1;
        samp();
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_first_grant: ready0=%b ready1=%b want 1 0", req0_ready, req1_ready); end
    endtask

    task automatic test_single_read();
        do_reset();
        preload(5'h0A, 32'hDEADBEEF);
        req0_valid = 1; req0_wr = 0; req0_addr = 5'h0A; req0_data = 32'h0BAD0BAD;
        samp();
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL read_accept: ready0=%b ready1=%b want 1 0", req0_ready, req1_ready); end
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) req0_valid = 0;
            samp();
            if (k == 1) begin
                vectors++; if (mem_addr !== 5'h0A || mem_wr !== 1'b0) begin miscompares++; $display("FAIL read_issue: addr=%h wr=%b want 0a 0", mem_addr, mem_wr); end
            end
            vectors++; if (rsp0_valid !== (k == 3)) begin miscompares++; $display("FAIL read_rsp_valid A+%0d: got %b want %b", k, rsp0_valid, k == 3); end
            vectors++; if (rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL read_rsp1_quiet A+%0d: got %b want 0", k, rsp1_valid); end
            if (k == 3) begin
                vectors++; if (rsp0_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_rsp_data: got %h want deadbeef", rsp0_data); end
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        req1_valid = 1; req1_wr = 1; req1_addr = 5'h1F; req1_data = 32'h12345678;
        samp();
        vectors++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin miscompares++; $display("FAIL write_accept: ready1=%b ready0=%b want 1 0", req1_ready, req0_ready); end
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) req1_valid = 0;
            samp();
            vectors++; if (mem_wr !== (k == 1)) begin miscompares++; $display("FAIL write_mem_wr A+%0d: got %b want %b", k, mem_wr, k == 1); end
            if (k == 1) begin
                vectors++; if (mem_addr !== 5'h1F || mem_data !== 32'h12345678) begin miscompares++; $display("FAIL write_issue: addr=%h data=%h want 1f 12345678", mem_addr, mem_data); end
            end
            vectors++; if (rsp1_valid !== (k == 3) || rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL write_rsp_valid A+%0d: rsp1=%b rsp0=%b want %b 0", k, rsp1_valid, rsp0_valid, k == 3); end
            if (k == 3) begin
                vectors++; if (rsp1_data !== 32'h12345678) begin miscompares++; $display("FAIL write_echo: got %h want 12345678", rsp1_data); end
            end
        end
    endtask

    task automatic test_contention();
        int g, gp;
        do_reset();
        req0_valid = 1; req0_addr = 5'd1;
        req1_valid = 1; req1_addr = 5'd2;
        for (int k = 0; k < 12; k++) begin
`ifdef CASH_ARB_FIXED_PRIO_EN
            g = 0; gp = 0;
`else
            g = (k / 3) % 2; gp = ((k / 3) + 1) % 2;
`endif
            samp();
            vectors++; if (req0_ready !== (k % 3 == 0 && g == 0) || req1_ready !== (k % 3 == 0 && g == 1)) begin
                miscompares++; $display("FAIL contention_grant k=%0d: ready0=%b ready1=%b want %b %b", k, req0_ready, req1_ready, k % 3 == 0 && g == 0, k % 3 == 0 && g == 1); end
            vectors++; if (rsp0_valid !== (k >= 3 && k % 3 == 0 && gp == 0) || rsp1_valid !== (k >= 3 && k % 3 == 0 && gp == 1)) begin
                miscompares++; $display("FAIL contention_rsp k=%0d: rsp0=%b rsp1=%b", k, rsp0_valid, rsp1_valid); end
            step();
            if (k % 3 == 0) begin
                if (g == 0) req0_addr = 5'($urandom); else req1_addr = 5'($urandom);
            end
        end
    endtask

    task automatic test_latency();
        int a;
        do_reset();
        a = cyc;
        b_req0_valid = 1; b_req0_wr = 0; b_req0_addr = 5'd7; b_req0_data = 32'h55;
        b_req1_valid = 1; b_req1_wr = 0; b_req1_addr = 5'd9;
        samp();
        vectors++; if (b_req0_ready !== 1'b1 || b_req1_ready !== 1'b0) begin miscompares++; $display("FAIL lat_accept: ready0=%b ready1=%b want 1 0", b_req0_ready, b_req1_ready); end
        vectors++; if (b_rsp1_data !== '0) begin miscompares++; $display("FAIL lat_rsp1_data_reset: got %h want 0", b_rsp1_data); end
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) b_req0_valid = 0;
            samp();
            if (k == 1) begin
                vectors++; if (b_mem_addr !== 5'd7 || b_mem_data !== 32'h55) begin miscompares++; $display("FAIL lat_issue: addr=%h data=%h want 07 55", b_mem_addr, b_mem_data); end
            end
            vectors++; if (b_mem_wr !== 1'b0) begin miscompares++; $display("FAIL lat_mem_wr A+%0d: got %b want 0", k, b_mem_wr); end
            vectors++; if (b_rsp0_valid !== (k == 5) || b_rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL lat_rsp_valid A+%0d: rsp0=%b rsp1=%b want %b 0", k, b_rsp0_valid, b_rsp1_valid, k == 5); end
            vectors++; if (b_req1_ready !== (k == 5)) begin miscompares++; $display("FAIL lat_next_accept A+%0d: got %b want %b", k, b_req1_ready, k == 5); end
            if (k == 5) begin
                vectors++; if (b_rsp0_data !== DW'(a + 4)) begin miscompares++; $display("FAIL lat_rsp_data: got %0d want %0d", b_rsp0_data, a + 4); end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        preload(5'h1F, 32'hCAFEF00D);
        req0_valid = 1; req0_wr = 0; req0_addr = 5'd2;
        samp();
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_accept: got %b want 1", req0_ready); end
        step(); req0_valid = 0;
        step(); rst_n = 0; req1_valid = 1; req1_wr = 0; req1_addr = 5'h1F;
        samp();
        vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready_forced: got %b want 0", req1_ready); end
        step(); rst_n = 1;
        samp();
        vectors++; if (rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_dropped_rsp: got %b want 0", rsp0_valid); end
        vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_next_accept: got %b want 1", req1_ready); end
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) req1_valid = 0;
            samp();
            if (k == 1) begin
                vectors++; if (mem_addr !== 5'h1F || mem_wr !== 1'b0) begin miscompares++; $display("FAIL midrst_issue: addr=%h wr=%b want 1f 0", mem_addr, mem_wr); end
            end
            vectors++; if (rsp0_valid !== 1'b0 || rsp1_valid !== (k == 3)) begin miscompares++; $display("FAIL midrst_rsp B+%0d: rsp0=%b rsp1=%b want 0 %b", k, rsp0_valid, rsp1_valid, k == 3); end
            if (k == 3) begin
                vectors++; if (rsp1_data !== 32'hCAFEF00D) begin miscompares++; $display("FAIL midrst_rsp_data: got %h want cafef00d", rsp1_data); end
            end
        end
        // Client 0 wins (rr -> 1), reset drops it, then a tie must go back to client 0
        step(); req0_valid = 1; req0_addr = 5'd4;
        step(); req0_valid = 0;
        step(); rst_n = 0;
        step(); rst_n = 1; req0_valid = 1; req1_valid = 1;
        samp();
        vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_rr_restart: ready0=%b ready1=%b want 1 0", req0_ready, req1_ready); end
        vectors++; if (rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_dropped_rsp2: got %b want 0", rsp0_valid); end
    endtask

    task automatic test_random();
        bit            have [2];
        bit            pwr [2];
        logic [4:0]    paddr [2];
        logic [DW-1:0] pdata [2];
        logic [DW-1:0] ref_mem [32];
        logic [DW-1:0] exp_rd [2];
        logic [4:0]    nxt_addr, exp_addr;
        logic [DW-1:0] nxt_data, exp_data, rsp_val;
        bit            nxt_wr;
        int            free_at, iss_cyc, rsp_cyc, rsp_own, g, rr_m;
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            ref_mem[a] = $urandom;
            preload(a[4:0], ref_mem[a]);
        end
        do_reset();
        have[0] = 0; have[1] = 0; pwr[0] = 0; pwr[1] = 0;
        paddr[0] = '0; paddr[1] = '0; pdata[0] = '0; pdata[1] = '0;
        exp_rd[0] = '0; exp_rd[1] = '0; exp_addr = '0; exp_data = '0;
        nxt_addr = '0; nxt_data = '0; nxt_wr = 0; rsp_val = '0;
        rr_m = 0; free_at = cyc; iss_cyc = -1; rsp_cyc = -1; rsp_own = 0;
        for (int n = 0; n < 400; n++) begin
            int c;
            c = cyc;
            for (int i = 0; i < 2; i++) begin
                if (!have[i] && $urandom_range(0, 2) != 0) begin
                    have[i] = 1; pwr[i] = 1'($urandom_range(0, 1));
                    paddr[i] = 5'($urandom); pdata[i] = $urandom;
                end
            end
            req0_valid = have[0]; req0_wr = pwr[0]; req0_addr = paddr[0]; req0_data = pdata[0];
            req1_valid = have[1]; req1_wr = pwr[1]; req1_addr = paddr[1]; req1_data = pdata[1];
            g = -1;
            if (c >= free_at) begin
                if (have[0] && have[1]) begin
`ifdef CASH_ARB_FIXED_PRIO_EN
                    g = 0;
`else
                    g = rr_m;
`endif
                end else if (have[0]) g = 0;
                else if (have[1]) g = 1;
            end
            if (c == iss_cyc) begin exp_addr = nxt_addr; exp_data = nxt_data; end
            if (c == rsp_cyc) exp_rd[rsp_own] = rsp_val;
            samp();
            vectors++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin miscompares++; $display("FAIL rand_ready cyc=%0d: ready0=%b ready1=%b want %b %b", c, req0_ready, req1_ready, g == 0, g == 1); end
            vectors++; if (mem_wr !== (c == iss_cyc && nxt_wr)) begin miscompares++; $display("FAIL rand_mem_wr cyc=%0d: got %b want %b", c, mem_wr, c == iss_cyc && nxt_wr); end
            vectors++; if (mem_addr !== exp_addr || mem_data !== exp_data) begin miscompares++; $display("FAIL rand_mem_bus cyc=%0d: addr=%h data=%h want %h %h", c, mem_addr, mem_data, exp_addr, exp_data); end
            vectors++; if (rsp0_valid !== (c == rsp_cyc && rsp_own == 0) || rsp1_valid !== (c == rsp_cyc && rsp_own == 1)) begin miscompares++; $display("FAIL rand_rsp_valid cyc=%0d: rsp0=%b rsp1=%b", c, rsp0_valid, rsp1_valid); end
            vectors++; if (rsp0_data !== exp_rd[0] || rsp1_data !== exp_rd[1]) begin miscompares++; $display("FAIL rand_rsp_data cyc=%0d: got %h %h want %h %h", c, rsp0_data, rsp1_data, exp_rd[0], exp_rd[1]); end
            if (g >= 0) begin
                nxt_addr = paddr[g]; nxt_data = pdata[g]; nxt_wr = pwr[g];
                if (pwr[g]) begin
                    ref_mem[paddr[g]] = pdata[g];
                    rsp_val = pdata[g];
                end else begin
                    rsp_val = ref_mem[paddr[g]];
                end
                iss_cyc = c + 1; rsp_cyc = c + 3; rsp_own = g; free_at = c + 3;
                rr_m = 1 - g; have[g] = 0;
            end
            step();
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_latency();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cash_port_arbiter.md
Name: cash_port_arbiter

Overview:
- Two-client arbiter and sequencer in front of the single-port cache/RAM (simple_cash / simple_ram port: addr, data, wr, q).
- Accepts read/write requests from two requesters (e.g. fetch and load/store) over a valid/ready handshake and grants them round-robin.
- Drives the memory port for exactly one issue cycle, waits a fixed memory latency, captures q and returns a one-cycle response to the granted client.
- One request in flight at a time.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the issue cycle to the cycle in which mem_q is valid; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  client 0 request valid.
- req0_ready  out  1  client 0 request accepted this cycle.
- req0_wr  in  1  client 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  client 0 address.
- req0_data  in  DATA_W  client 0 write data.
- rsp0_valid  out  1  client 0 response strobe, one cycle.
- rsp0_data  out  DATA_W  client 0 read data, or echoed write data.
- req1_valid, req1_ready, req1_wr, req1_addr, req1_data, rsp1_valid, rsp1_data: same as client 0, for client 1.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data  out  DATA_W  to memory data.
- mem_wr  out  1  to memory wr.
- mem_q  in  DATA_W  from memory q.

Behaviour:
- States: IDLE, ISSUE, WAIT. Internal state: rr pointer (1 bit), wait counter (3 bits), latched wr/addr/data/owner.
- Reset (rst_n low at a rising edge): state IDLE, rr=0, counter=0, mem_addr=0, mem_data=0, mem_wr=0, rsp0/1_valid=0, rsp0/1_data=0.
- While rst_n is low, req0_ready and req1_ready are forced 0.
- Reset mid-operation: in-flight request is dropped with no response, and mem_wr drops at that edge.
- IDLE arbitration: grant = the only valid client; if both are valid, grant = rr. req_ready is combinational, high only for the granted client, only in IDLE. The other ready is 0.
- Handshake: valid && ready latches wr/addr/data/owner, sets rr = other client, and moves to ISSUE. Requesters hold valid and payload stable until ready.
- ISSUE (1 cycle): mem_addr/mem_data = latched values; mem_wr = latched wr for this cycle only. Counter = MEM_LAT. Go to WAIT.
- WAIT (MEM_LAT cycles): mem_addr/mem_data stay stable, mem_wr=0, counter decrements.
  - On the last WAIT cycle (counter==1), rsp_data of the owner captures mem_q for a read, or the latched write data for a write. Go to IDLE.
- The owner's rsp_valid is registered. It is high for exactly one cycle: the first IDLE cycle after WAIT.
- A new request may be accepted in that same cycle.
- Timing: accept at cycle A; mem_wr/issue at A+1; mem_q sampled at A+1+MEM_LAT; rsp_valid at A+2+MEM_LAT.
- Throughput: one request per MEM_LAT+2 cycles.
- rsp_data holds its value until the next response to that client.
- Non-owner rsp_valid is always 0.
- No valid in IDLE: stay in IDLE, mem_wr=0, mem_addr/mem_data hold their last values.

Optional Feature:
- Macro CASH_ARB_FIXED_PRIO_EN.
- Defined: client 0 always wins when both clients are valid; rr is not used (may be left unimplemented).
- Undefined: round-robin as described above.
- All other timing is identical in both builds.

Test Plan:
- Reset: rst_n low 3 cycles with req0_valid=req1_valid=1 -> req0_ready=req1_ready=0, mem_wr=0, rsp0/1_valid=0. After release, first grant goes to client 0.
- Single read, MEM_LAT=1: client 0 addr 5'h0A, memory model returns 32'hDEADBEEF -> req0_ready at A; mem_addr=5'h0A and mem_wr=0 at A+1; rsp0_valid=1 and rsp0_data=32'hDEADBEEF at A+3 only; rsp1_valid stays 0.
- Write: client 1 addr 5'h1F data 32'h12345678 -> mem_wr=1 for exactly cycle A+1 with mem_addr=5'h1F and mem_data=32'h12345678; rsp1_valid at A+3 with rsp1_data=32'h12345678.
- Contention: both clients hold valid continuously after reset -> grants 0,1,0,1 every 3 cycles (MEM_LAT=1). With CASH_ARB_FIXED_PRIO_EN, grants are 0,0,0,0.
- Latency, MEM_LAT=3: memory model changes mem_q every cycle (value = cycle number) -> rsp at A+5, rsp_data equals the mem_q value of cycle A+4.
- Reset mid-WAIT: assert rst_n low for 1 cycle during WAIT -> no rsp_valid for the dropped request. The next request from client 1 completes normally with standard timing, and rr restarts at 0.
